// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional DIV_FAST_ZERO_EN: a zero divisor skips the iterations and goes straight from START to END.
module div_unit #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [2:0]      op_i,
    input  logic [RAW-1:0]  reg_waddr_i,
    input  logic            start_i,
    output logic [XLEN-1:0] result_o,
    output logic            ready_o,
    output logic            busy_o,
    output logic [RAW-1:0]  reg_waddr_o
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {S_IDLE, S_START, S_CALC, S_END} state_t;
    state_t state, state_nx;
    logic [XLEN-1:0] a_r, b_r, dvd, dvs, quo, rem, rem_sh;
    logic [1:0]      op_r;
    logic [RAW-1:0]  waddr_r;
    logic [CW-1:0]   cnt;
    logic            q_neg, r_neg, sgn, zero, is_rem, fit;
    assign sgn    = ~op_r[0];
    assign is_rem = op_r[1];
    assign zero   = b_r == '0;
    assign rem_sh = {rem[XLEN-2:0], dvd[XLEN-1]};
    assign fit    = rem_sh >= dvs;
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = start_i ? S_START : S_IDLE;
`ifdef DIV_FAST_ZERO_EN
            S_START: state_nx = !start_i ? S_IDLE : zero ? S_END : S_CALC;
`else
            S_START: state_nx = !start_i ? S_IDLE : S_CALC;
`endif
            S_CALC:  state_nx = !start_i ? S_IDLE : cnt == CW'(XLEN-1) ? S_END : S_CALC;
            default: state_nx = S_IDLE;
        endcase
    end
    always_comb begin
        ready_o     = state == S_END;
        busy_o      = state != S_IDLE;
        reg_waddr_o = state == S_END ? waddr_r : '0;
        result_o    = state != S_END ? '0 :
                      zero ? (is_rem ? a_r : '1) :
                      is_rem ? (r_neg ? -rem : rem) : (q_neg ? -quo : quo);
    end
    // Signed ops divide magnitudes; signs are reapplied when the result is presented.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            a_r <= '0; b_r <= '0; op_r <= '0; waddr_r <= '0;
            dvd <= '0; dvs <= '0; quo <= '0; rem <= '0; cnt <= '0;
            q_neg <= 1'b0; r_neg <= 1'b0;
        end else case (state)
            S_IDLE: if (start_i) begin
                a_r     <= dividend_i;
                b_r     <= divisor_i;
                op_r    <= op_i[2] ? op_i[1:0] : 2'b01;
                waddr_r <= reg_waddr_i;
            end
            S_START: begin
                dvd   <= sgn && a_r[XLEN-1] ? -a_r : a_r;
                dvs   <= sgn && b_r[XLEN-1] ? -b_r : b_r;
                q_neg <= sgn & (a_r[XLEN-1] ^ b_r[XLEN-1]);
                r_neg <= sgn & a_r[XLEN-1];
                rem   <= '0;
                quo   <= '0;
                cnt   <= '0;
            end
            S_CALC: begin
                rem <= fit ? rem_sh - dvs : rem_sh;
                quo <= {quo[XLEN-2:0], fit};
                dvd <= dvd << 1;
                cnt <= cnt + CW'(1);
            end
            default: ;
        endcase
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors with a queue scoreboard checked by a separate monitor.
module tb_div_unit;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
`ifdef DIV_FAST_ZERO_EN
    localparam int ZL = 2;
`else
    localparam int ZL = 34;
`endif
    typedef struct {
        logic [31:0] res;
        logic [4:0]  wa;
        int          t0;
        int          lat;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] dividend_i = '0, divisor_i = '0;
    logic [2:0]  op_i = '0;
    logic [4:0]  reg_waddr_i = '0;
    logic        start_i = 1'b0;
    logic [31:0] result_o;
    logic        ready_o, busy_o;
    logic [4:0]  reg_waddr_o;
    int checks = 0, errors = 0, cyc = 0;
    exp_t q[$];
    div_unit dut (
        .clk(clk), .rst(rst), .dividend_i(dividend_i), .divisor_i(divisor_i),
        .op_i(op_i), .reg_waddr_i(reg_waddr_i), .start_i(start_i),
        .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o), .reg_waddr_o(reg_waddr_o)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin : monitor
        exp_t m;
        if (rst) begin
            if (ready_o) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ready result=%h", result_o);
                end else begin
                    m = q.pop_front();
                    checks += 3;
                    if (result_o !== m.res) begin
                        errors++; $display("FAIL result got=%h exp=%h", result_o, m.res);
                    end
                    if (reg_waddr_o !== m.wa) begin
                        errors++; $display("FAIL waddr got=%0d exp=%0d", reg_waddr_o, m.wa);
                    end
                    if (cyc - m.t0 != m.lat) begin
                        errors++; $display("FAIL latency got=%0d exp=%0d", cyc - m.t0, m.lat);
                    end
                end
            end else begin
                checks++;
                if (result_o !== '0 || reg_waddr_o !== '0) begin
                    errors++; $display("FAIL idle_outputs result=%h waddr=%0d exp=0", result_o, reg_waddr_o);
                end
            end
        end
    end
    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa, input logic [31:0] res, input int lat);
        exp_t e;
        bit got = 0;
        @(negedge clk);
        dividend_i = a; divisor_i = b; op_i = op; reg_waddr_i = wa; start_i = 1'b1;
        e.res = res; e.wa = wa; e.t0 = cyc; e.lat = lat;
        q.push_back(e);
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (i == 1) begin
                dividend_i = $urandom; divisor_i = $urandom;
                op_i = 3'($urandom_range(7, 0)); reg_waddr_i = 5'($urandom_range(31, 0));
            end
            got = ready_o;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL timeout op=%b a=%h b=%h", op, a, b);
            void'(q.pop_front());
        end
        start_i = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL busy_after_ready got=%b exp=0", busy_o);
        end
    endtask
    initial begin
        #3;
        checks++;
        if (result_o !== '0 || ready_o !== 1'b0 || busy_o !== 1'b0 || reg_waddr_o !== '0) begin
            errors++; $display("FAIL reset_state r=%h rdy=%b busy=%b wa=%0d exp=0", result_o, ready_o, busy_o, reg_waddr_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run(DIVU, 32'h64, 32'h7, 5'd5, 32'h0000000E, 34);
        run(REM,  32'hFFFFFF9C, 32'h7, 5'd6, 32'hFFFFFFFE, 34);
        run(DIV,  32'hFFFFFF9C, 32'h7, 5'd7, 32'hFFFFFFF2, 34);
        run(DIV,  32'h80000000, 32'hFFFFFFFF, 5'd8, 32'h80000000, 34);
        run(REM,  32'h80000000, 32'hFFFFFFFF, 5'd9, 32'h00000000, 34);
        run(DIV,  32'h64, 32'hFFFFFFF9, 5'd10, 32'hFFFFFFF2, 34);
        run(REM,  32'h64, 32'hFFFFFFF9, 5'd11, 32'h00000002, 34);
        run(REMU, 32'h7, 32'h64, 5'd12, 32'h00000007, 34);
        run(DIVU, 32'hFFFFFFFF, 32'h1, 5'd31, 32'hFFFFFFFF, 34);
        run(3'b000, 32'hFFFFFF9C, 32'h7, 5'd13, 32'h24924916, 34);
        run(DIVU, 32'h1234, 32'h0, 5'd14, 32'hFFFFFFFF, ZL);
        run(REMU, 32'h1234, 32'h0, 5'd15, 32'h00001234, ZL);
        run(DIV,  32'hFFFFFFF9, 32'h0, 5'd16, 32'hFFFFFFFF, ZL);
        run(REM,  32'hFFFFFFF9, 32'h0, 5'd17, 32'hFFFFFFF9, ZL);
        // abort mid-calculation, then relaunch at once
        @(negedge clk);
        dividend_i = 32'h64; divisor_i = 32'h7; op_i = DIVU; reg_waddr_i = 5'd20; start_i = 1'b1;
        repeat (10) @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL abort_busy got=%b exp=0", busy_o);
        end
        run(DIVU, 32'h9, 32'h3, 5'd21, 32'h00000003, 34);
        // asynchronous reset mid-calculation
        @(negedge clk);
        dividend_i = 32'h64; divisor_i = 32'h7; op_i = DIVU; reg_waddr_i = 5'd22; start_i = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++; $display("FAIL busy_in_calc got=%b exp=1", busy_o);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (result_o !== '0 || ready_o !== 1'b0 || busy_o !== 1'b0 || reg_waddr_o !== '0) begin
            errors++; $display("FAIL async_reset r=%h rdy=%b busy=%b wa=%0d exp=0", result_o, ready_o, busy_o, reg_waddr_o);
        end
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset busy=%b rdy=%b exp=0", busy_o, ready_o);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL pending_results got=%0d exp=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 divider for RV32M DIV/DIVU/REM/REMU.
- Responder side of the EX-stage divide handshake: EX raises start_i (DivStart) and holds the pipeline with Pipe_Pause until ready_o.
- Sits beside ex.
- Returns the result and destination register address to EX for writeback.

Parameters:
- XLEN, 32, operand/result width (RegBus); iteration count equals XLEN.
- RAW, 5, register address width (RegAddrBus).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (RstEnable = 1'b0).
- dividend_i  input  XLEN  rs1 value, sampled at launch.
- divisor_i  input  XLEN  rs2 value, sampled at launch.
- op_i  input  3  funct3: INST_DIV 100, INST_DIVU 101, INST_REM 110, INST_REMU 111; sampled at launch.
- reg_waddr_i  input  RAW  destination register, sampled at launch.
- start_i  input  1  DivStart/DivStop request level; must stay high until ready_o.
- result_o  output  XLEN  quotient or remainder; valid only while ready_o=1, else 0.
- ready_o  output  1  one-cycle completion pulse.
- busy_o  output  1  high in every non-IDLE state.
- reg_waddr_o  output  RAW  latched destination; valid with ready_o, else 0.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; internal quotient, remainder, counter and operand registers 0.
- States: IDLE, START, CALC, END.
- IDLE: on clock edge with start_i=1, latch operands, op and waddr; go to START. start_i=0: stay.
- START:
  - Signed ops (DIV/REM): take absolute values of both operands.
  - Record quotient sign = sign(dividend)^sign(divisor), remainder sign = sign(dividend).
  - Clear remainder, count=0; go to CALC.
- CALC, one iteration per cycle, restoring algorithm:
  - rem = {rem[XLEN-2:0], dividend msb}; dividend shifts left.
  - If rem >= divisor: rem -= divisor, shift 1 into quotient; else shift 0.
  - After iteration XLEN-1 (count==XLEN-1), go to END.
- END:
  - ready_o=1 and busy_o=1 for exactly one cycle; reg_waddr_o = latched waddr.
  - result_o = quotient (DIV/DIVU) or remainder (REM/REMU), sign-corrected for DIV/REM; next state IDLE.
- Latency: start sampled at edge T puts state in START; ready_o is high in the cycle after edge T+XLEN+1 (34 clocks for XLEN=32); busy_o high from edge T to edge T+XLEN+2.
- Divide by zero (divisor==0), spec-exact results: DIV/DIVU quotient = all ones; REM/REMU = original dividend. The override is applied in END regardless of signedness.
- Overflow (DIV 0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0. This falls out of the unsigned-magnitude path with no special case.
- Abort: start_i=0 observed in START or CALC returns to IDLE at that edge. No ready_o; outputs stay 0. This covers the flush/interrupt case.
- start_i in END is ignored. The requester drops start_i in the ready_o cycle; start_i still high in IDLE the following cycle launches a new operation.
- Operand inputs are ignored after launch; changes mid-operation have no effect.
- Invalid op_i (bit2=0) at launch is treated as DIVU.

Optional Feature:
- Macro DIV_FAST_ZERO_EN.
- Defined: START detects divisor==0 and jumps directly to END. ready_o rises 2 cycles after launch, with the same zero-divide results.
- Undefined: zero-divide takes the full XLEN+2 latency, and results are overridden in END.
- All other cases are identical either way.

Test Plan:
- DIVU 100/7 (dividend 0x64, divisor 0x7), waddr 5 -> ready_o pulse 34 cycles after launch, result 0x0000000E, reg_waddr_o 5, busy_o low the next cycle.
- REM 0xFFFFFF9C(-100)/7 -> result 0xFFFFFFFE (-2). Then DIV -100/7 -> 0xFFFFFFF2 (-14).
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000. Then REM with the same operands -> 0x00000000.
- DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x00001234. Latency 34 without DIV_FAST_ZERO_EN, 2 with it.
- Launch DIVU, drop start_i at cycle 10 -> busy_o low next cycle, no ready_o. Immediate relaunch of DIVU 9/3 -> result 3.
- Assert rst low mid-CALC -> all outputs 0 immediately (async). After release with start_i low, state stays IDLE and busy_o=0.
